execute_cond_stage: RTL and testbench
=====================================

Name: execute_cond_stage

Overview:
- Decode-to-execute pipeline register for the control bundle produced by decode.
- Owns the architectural NZCV flags register.
- Evaluates the 4-bit condition field against the stored flags and gates register write, memory write and branch taken.
- Generates the wrong-path flush on a taken branch and keeps a saturating taken-branch counter for bring-up.

Parameters:
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- d_valid  in  1  decode slot holds a real instruction
- d_FlagW  in  1  instruction writes flags
- d_PCS  in  1  instruction is a branch
- d_RegW  in  1  register write request
- d_MemW  in  1  memory write request
- d_MemtoReg  in  1  writeback selects memory data
- d_ALUSrc  in  1  ALU source B select
- d_ALUControl  in  3  ALU operation
- d_Cond  in  4  condition code
- stall_e  in  1  hold the execute register (hazard unit)
- flush_e  in  1  insert a bubble into execute (hazard unit)
- alu_flags  in  4  NZCV from the ALU for the instruction in execute (N=bit3, Z=2, C=1, V=0)
- e_valid  out  1  execute slot valid
- e_MemtoReg, e_ALUSrc  out  1 each  registered pass-through
- e_ALUControl  out  3  registered pass-through
- e_Cond  out  4  registered condition
- CondEx  out  1  condition passes for the current execute instruction
- RegWrite_e  out  1  e_valid & e_RegW & CondEx
- MemWrite_e  out  1  e_valid & e_MemW & CondEx
- PCSrc_e  out  1  e_valid & e_PCS & CondEx (branch taken)
- branch_flush  out  1  equals PCSrc_e; flushes fetch/decode
- flags_q  out  4  architectural NZCV
- taken_cnt  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (rst_n low, asynchronous):
  - All execute-register fields, including e_valid, are 0.
  - flags_q = 0000; taken_cnt = 0.
  - All gated outputs are therefore 0.
- Execute register update, each rising clk, in priority order:
  1. flush_e or PCSrc_e: load a bubble (e_valid = 0, every control field 0, e_Cond = 1110).
  2. stall_e: hold all fields.
  3. Otherwise: load the d_* fields, with e_valid = d_valid.
  - A taken branch overrides stall, so the wrong-path instruction in decode never enters execute.
- Condition check (combinational on e_Cond and flags_q, never on alu_flags):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & N==V
  - 1101 LE: Z | N!=V
  - 1110 AL: 1
  - Every other code, including 1111: 0.
- Flags update:
  - flags_q <= alu_flags at a clock edge when e_valid & e_FlagW & CondEx & ~stall_e.
  - The update happens once, when the instruction leaves execute.
  - A stalled CMP does not write until it is released.
  - A flags write and a flags read by a conditional instruction in the following cycle is exact: that instruction sees the new flags, one-cycle latency.
- Gating:
  - Gated outputs are purely combinational from registered state, so the branch decision is available in the same cycle the branch is in execute.
  - A bubble, or a failed condition, drives RegWrite_e, MemWrite_e and PCSrc_e to 0 and blocks the flags write.
- Counter:
  - taken_cnt increments by 1 on each clock edge where PCSrc_e & ~stall_e.
  - It saturates at all-ones and holds there; it does not wrap.
- Reset mid-operation: asynchronous clear of everything, with no partial updates. The first edge after deassertion behaves as a normal load.
- A stall combined with an untaken branch holds the branch in execute; its condition is re-evaluated each cycle on unchanged flags.

Decomposition:
- Shared package cpu_pkg holds:
  - cond_t enum: COND_EQ, NE, GE, LT, GT, LE, AL.
  - alu_ctrl_t enum: ADD 000, SUB 001, MULT 010, LSR 011, LSL 100, PASSA 101, PASSB 110.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, cond_check (inputs cond, flags; output pass), instantiated once.

Test Plan:
- Reset held with d_valid=1, d_RegW=1 -> after release, e_valid=0, RegWrite_e=0, flags_q=0000, taken_cnt=0; the first clk edge loads the instruction, giving RegWrite_e=1.
- CMP (FlagW=1, ALUControl=001, Cond=1110) with alu_flags=1000, followed by a branch with Cond=1011 -> flags_q=1000 after CMP leaves execute; PCSrc_e=1 and branch_flush=1 in the branch cycle; the next execute slot is a bubble; taken_cnt=1.
- Same sequence with alu_flags=0000 -> LT fails; PCSrc_e=0; the following instruction enters execute normally; taken_cnt=0.
- Instruction with Cond=1111, RegW=1, MemW=1, FlagW=1 -> RegWrite_e=0, MemWrite_e=0, flags_q unchanged.
- CMP held 3 cycles with stall_e=1 while alu_flags changes 0100 -> 0001 -> 1000, then released with 0010 -> flags_q changes only at the release edge, to 0010; execute fields are constant during the stall.
- Force taken_cnt to all-ones (CNT_W=4 build, 16 taken branches) -> taken_cnt stays at 1111 on the 16th and later taken branches.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute-stage control path.
package cpu_pkg;

    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned ALU_W   = 3;

    // Bit positions within the NZCV flags vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110
    } cond_t;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_MULT  = 3'b010,
        ALU_LSR   = 3'b011,
        ALU_LSL   = 3'b100,
        ALU_PASSA = 3'b101,
        ALU_PASSB = 3'b110
    } alu_ctrl_t;

    // Control bundle held in the execute register
    typedef struct packed {
        logic              valid;
        logic              flag_w;
        logic              pcs;
        logic              reg_w;
        logic              mem_w;
        logic              mem_to_reg;
        logic              alu_src;
        logic [ALU_W-1:0]  alu_control;
        logic [COND_W-1:0] cond;
    } ctrl_t;

    // Bubble: nothing valid, condition AL so a bubble never reads as a failed condition
    localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      3'b000, 4'b1110};

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluator against the stored NZCV flags.
module cond_check
    import cpu_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               pass
);

    logic n;
    logic z;
    logic v;
    logic unused_c;

    assign n        = flags[FLAG_N];
    assign z        = flags[FLAG_Z];
    assign v        = flags[FLAG_V];
    assign unused_c = flags[FLAG_C];

    // Decode the condition; unlisted codes (including 1111) never pass
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_cond_stage.sv
// Decode-to-execute control register, NZCV flags, conditional gating,
// taken-branch flush and a saturating taken-branch counter.
module execute_cond_stage
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    input  logic             d_FlagW,
    input  logic             d_PCS,
    input  logic             d_RegW,
    input  logic             d_MemW,
    input  logic             d_MemtoReg,
    input  logic             d_ALUSrc,
    input  logic [2:0]       d_ALUControl,
    input  logic [3:0]       d_Cond,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic [3:0]       alu_flags,
    output logic             e_valid,
    output logic             e_MemtoReg,
    output logic             e_ALUSrc,
    output logic [2:0]       e_ALUControl,
    output logic [3:0]       e_Cond,
    output logic             CondEx,
    output logic             RegWrite_e,
    output logic             MemWrite_e,
    output logic             PCSrc_e,
    output logic             branch_flush,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] taken_cnt
);

    ctrl_t e_q;
    ctrl_t e_d;
    logic  flags_we;
    logic  cnt_inc;

    cond_check u_cond_check (
        .cond  (e_q.cond),
        .flags (flags_q),
        .pass  (CondEx)
    );

    assign e_valid      = e_q.valid;
    assign e_MemtoReg   = e_q.mem_to_reg;
    assign e_ALUSrc     = e_q.alu_src;
    assign e_ALUControl = e_q.alu_control;
    assign e_Cond       = e_q.cond;

    // Gated controls come straight from registered state so a branch resolves in its own cycle
    assign RegWrite_e   = e_q.valid & e_q.reg_w & CondEx;
    assign MemWrite_e   = e_q.valid & e_q.mem_w & CondEx;
    assign PCSrc_e      = e_q.valid & e_q.pcs & CondEx;
    assign branch_flush = PCSrc_e;

    assign flags_we = e_q.valid & e_q.flag_w & CondEx & ~stall_e;
    assign cnt_inc  = PCSrc_e & ~stall_e;

    // Next execute contents: bubble on flush or taken branch, else hold on stall, else load
    always_comb begin
        e_d = e_q;
        if (flush_e || PCSrc_e) begin
            e_d = CTRL_BUBBLE;
        end else if (!stall_e) begin
            e_d.valid       = d_valid;
            e_d.flag_w      = d_FlagW;
            e_d.pcs         = d_PCS;
            e_d.reg_w       = d_RegW;
            e_d.mem_w       = d_MemW;
            e_d.mem_to_reg  = d_MemtoReg;
            e_d.alu_src     = d_ALUSrc;
            e_d.alu_control = d_ALUControl;
            e_d.cond        = d_Cond;
        end
    end

    // Execute register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    // Flags commit once, when a passing flag-setting instruction leaves execute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (flags_we) begin
            flags_q <= alu_flags;
        end
    end

    // Saturating taken-branch counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
        end else if (cnt_inc && (taken_cnt != {CNT_W{1'b1}})) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_execute_cond_stage.sv
// Randomized and directed bench for execute_cond_stage with a slot-level reference model.
module tb_execute_cond_stage;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    logic             clk;
    logic             rst_n;
    logic             d_valid, d_FlagW, d_PCS, d_RegW, d_MemW, d_MemtoReg, d_ALUSrc;
    logic [2:0]       d_ALUControl;
    logic [3:0]       d_Cond;
    logic             stall_e, flush_e;
    logic [3:0]       alu_flags;
    logic             e_valid, e_MemtoReg, e_ALUSrc;
    logic [2:0]       e_ALUControl;
    logic [3:0]       e_Cond;
    logic             CondEx, RegWrite_e, MemWrite_e, PCSrc_e, branch_flush;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] taken_cnt;

    int vec_n  = 0;
    int miss_n = 0;

    execute_cond_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_valid      (d_valid),
        .d_FlagW      (d_FlagW),
        .d_PCS        (d_PCS),
        .d_RegW       (d_RegW),
        .d_MemW       (d_MemW),
        .d_MemtoReg   (d_MemtoReg),
        .d_ALUSrc     (d_ALUSrc),
        .d_ALUControl (d_ALUControl),
        .d_Cond       (d_Cond),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .alu_flags    (alu_flags),
        .e_valid      (e_valid),
        .e_MemtoReg   (e_MemtoReg),
        .e_ALUSrc     (e_ALUSrc),
        .e_ALUControl (e_ALUControl),
        .e_Cond       (e_Cond),
        .CondEx       (CondEx),
        .RegWrite_e   (RegWrite_e),
        .MemWrite_e   (MemWrite_e),
        .PCSrc_e      (PCSrc_e),
        .branch_flush (branch_flush),
        .flags_q      (flags_q),
        .taken_cnt    (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction sitting in execute, the flags and the counter
    typedef struct {
        bit       valid, flagw, pcs, regw, memw, mtr, alusrc;
        bit [2:0] aluc;
        bit [3:0] cond;
    } slot_t;

    slot_t    m_e;
    bit [3:0] m_flags;
    int       m_cnt;

    function automatic bit cond_ok(bit [3:0] c, bit [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit v = f[0];
        case (int'(c))
            0:       return z;
            1:       return !z;
            10:      return n == v;
            11:      return n != v;
            12:      return !z && (n == v);
            13:      return z || (n != v);
            14:      return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic slot_t bubble();
        slot_t s = '{default: 0};
        s.cond = 4'b1110;
        return s;
    endfunction

    task automatic reset_model();
        m_e     = '{default: 0};
        m_flags = 4'b0000;
        m_cnt   = 0;
    endtask

    function automatic logic [22:0] exp_vec();
        bit p = cond_ok(m_e.cond, m_flags);
        bit t = m_e.valid && m_e.pcs && p;
        return {m_e.valid, m_e.mtr, m_e.alusrc, m_e.aluc, m_e.cond, p,
                m_e.valid && m_e.regw && p, m_e.valid && m_e.memw && p, t, t,
                m_flags, 4'(m_cnt)};
    endfunction

    function automatic logic [22:0] obs_vec();
        return {e_valid, e_MemtoReg, e_ALUSrc, e_ALUControl, e_Cond, CondEx,
                RegWrite_e, MemWrite_e, PCSrc_e, branch_flush, flags_q, taken_cnt};
    endfunction

    task automatic set_d(bit v, bit fw, bit pcs, bit rw, bit mw, bit mtr, bit as,
                         bit [2:0] ac, bit [3:0] c);
        d_valid = v; d_FlagW = fw; d_PCS = pcs; d_RegW = rw; d_MemW = mw;
        d_MemtoReg = mtr; d_ALUSrc = as; d_ALUControl = ac; d_Cond = c;
    endtask

    // Advance one clock; the model steps from the inputs presented before the edge
    task automatic tick();
        slot_t    nxt = m_e;
        bit [3:0] nf  = m_flags;
        int       nc  = m_cnt;
        bit       p   = cond_ok(m_e.cond, m_flags);
        bit       t   = m_e.valid && m_e.pcs && p;
        if (rst_n) begin
            if (flush_e || t) begin
                nxt = bubble();
            end else if (!stall_e) begin
                nxt = '{d_valid, d_FlagW, d_PCS, d_RegW, d_MemW, d_MemtoReg, d_ALUSrc,
                        d_ALUControl, d_Cond};
            end
            if (m_e.valid && m_e.flagw && p && !stall_e) nf = alu_flags;
            if (t && !stall_e) nc = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        @(posedge clk);
        m_e = nxt; m_flags = nf; m_cnt = nc;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_e = 0; flush_e = 0; alu_flags = 4'b0000;
        set_d(1, 0, 0, 1, 0, 0, 0, 3'b000, 4'b1110);
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        vec_n++;
        if ({e_valid, RegWrite_e} !== 2'b00) begin
            miss_n++; $display("FAIL reset_valid got %b exp 00", {e_valid, RegWrite_e});
        end
        vec_n++;
        if ({flags_q, taken_cnt} !== 8'h00) begin
            miss_n++; $display("FAIL reset_state got %h exp 00", {flags_q, taken_cnt});
        end
        rst_n = 1'b1;
        #1;
        vec_n++;
        if (obs_vec() !== exp_vec()) begin
            miss_n++; $display("FAIL reset_release got %h exp %h", obs_vec(), exp_vec());
        end
        tick();
        vec_n++;
        if (RegWrite_e !== 1'b1) begin
            miss_n++; $display("FAIL reset_first_load got %b exp 1", RegWrite_e);
        end
    endtask

    task automatic test_cmp_branch(bit [3:0] af, bit exp_taken, int exp_cnt);
        set_d(1, 1, 0, 0, 0, 0, 0, 3'b001, 4'b1110);
        alu_flags = af;
        tick();
        set_d(1, 0, 1, 0, 0, 0, 0, 3'b000, 4'b1011);
        tick();
        vec_n++;
        if (flags_q !== af) begin
            miss_n++; $display("FAIL cmp_flags got %b exp %b", flags_q, af);
        end
        vec_n++;
        if ({PCSrc_e, branch_flush} !== {exp_taken, exp_taken}) begin
            miss_n++; $display("FAIL branch_taken got %b exp %b", {PCSrc_e, branch_flush},
                               {exp_taken, exp_taken});
        end
        set_d(1, 0, 0, 1, 0, 1, 1, 3'b010, 4'b1110);
        tick();
        vec_n++;
        if ({e_valid, RegWrite_e} !== {!exp_taken, !exp_taken}) begin
            miss_n++; $display("FAIL after_branch got %b exp %b", {e_valid, RegWrite_e},
                               {!exp_taken, !exp_taken});
        end
        vec_n++;
        if (int'(taken_cnt) !== exp_cnt) begin
            miss_n++; $display("FAIL branch_cnt got %0d exp %0d", taken_cnt, exp_cnt);
        end
        vec_n++;
        if (obs_vec() !== exp_vec()) begin
            miss_n++; $display("FAIL branch_model got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_never_cond();
        set_d(1, 1, 0, 1, 1, 0, 0, 3'b001, 4'b1111);
        alu_flags = 4'b0110;
        tick();
        vec_n++;
        if ({CondEx, RegWrite_e, MemWrite_e} !== 3'b000) begin
            miss_n++; $display("FAIL never_gate got %b exp 000", {CondEx, RegWrite_e, MemWrite_e});
        end
        set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b1110);
        tick();
        vec_n++;
        if (flags_q !== 4'b0000) begin
            miss_n++; $display("FAIL never_flags got %b exp 0000", flags_q);
        end
    endtask

    task automatic test_stall();
        logic [3:0] seq [3];
        seq[0] = 4'b0100; seq[1] = 4'b0001; seq[2] = 4'b1000;
        set_d(1, 1, 0, 0, 0, 0, 0, 3'b001, 4'b1110);
        alu_flags = 4'b0100;
        tick();
        set_d(1, 0, 0, 1, 0, 1, 0, 3'b101, 4'b0000);
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_flags = seq[i];
            tick();
            vec_n++;
            if (flags_q !== 4'b0000) begin
                miss_n++; $display("FAIL stall_flags[%0d] got %b exp 0000", i, flags_q);
            end
            vec_n++;
            if ({e_valid, e_MemtoReg, e_ALUSrc, e_ALUControl, e_Cond} !== 10'b1_0_0_001_1110) begin
                miss_n++; $display("FAIL stall_hold[%0d] got %b exp 1000011110", i,
                                   {e_valid, e_MemtoReg, e_ALUSrc, e_ALUControl, e_Cond});
            end
        end
        stall_e = 1'b0;
        alu_flags = 4'b0010;
        tick();
        vec_n++;
        if (flags_q !== 4'b0010) begin
            miss_n++; $display("FAIL stall_release got %b exp 0010", flags_q);
        end
        vec_n++;
        if (obs_vec() !== exp_vec()) begin
            miss_n++; $display("FAIL stall_model got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            set_d(1, 0, 1, 0, 0, 0, 0, 3'b000, 4'b1110);
            tick();
            set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b1110);
            tick();
            vec_n++;
            if (int'(taken_cnt) !== ((k > CNT_MAX) ? CNT_MAX : k)) begin
                miss_n++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", k, taken_cnt,
                                   (k > CNT_MAX) ? CNT_MAX : k);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] codes [8];
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b1010; codes[3] = 4'b1011;
        codes[4] = 4'b1100; codes[5] = 4'b1101; codes[6] = 4'b1110; codes[7] = 4'b1111;
        for (int i = 0; i < 500; i++) begin
            set_d(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 3'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) != 0) ? codes[$urandom_range(0, 7)]
                                              : 4'($urandom_range(0, 15)));
            stall_e   = ($urandom_range(0, 4) == 0);
            flush_e   = ($urandom_range(0, 9) == 0);
            alu_flags = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #2;
                reset_model();
                vec_n++;
                if (obs_vec() !== exp_vec()) begin
                    miss_n++; $display("FAIL rand_async_reset[%0d] got %h exp %h", i,
                                       obs_vec(), exp_vec());
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            tick();
            vec_n++;
            if (obs_vec() !== exp_vec()) begin
                miss_n++; $display("FAIL rand[%0d] got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmp_branch(4'b1000, 1'b1, 1);
        test_cmp_branch(4'b0000, 1'b0, 1);
        test_never_cond();
        test_stall();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
